// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router write-side controller.
// State codes are plain 3-bit constants so legacy tooling can match them.
package router_pkg;

    localparam int NUM_DEST = 3;
    localparam int ADDR_W   = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t LOAD_FIRST_DATA    = 3'd1;
    localparam state_t LOAD_DATA          = 3'd2;
    localparam state_t WAIT_TILL_EMPTY    = 3'd3;
    localparam state_t FIFO_FULL_STATE    = 3'd4;
    localparam state_t LOAD_AFTER_FULL    = 3'd5;
    localparam state_t LOAD_PARITY        = 3'd6;
    localparam state_t CHECK_PARITY_ERROR = 3'd7;

    // Address 3 selects nothing, so it reads back as 0.
    function automatic logic pick_dest(
        input logic [NUM_DEST-1:0] vec,
        input logic [ADDR_W-1:0]   idx
    );
        logic r;
        r = 1'b0;
        case (idx)
            2'd0:    r = vec[0];
            2'd1:    r = vec[1];
            2'd2:    r = vec[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm_controller_if.sv
// Bundle between the packet source/register block/FIFOs and the controller.
// master drives the inputs of the controller; slave is the controller.
interface router_fsm_controller_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;
    logic [ADDR_W-1:0] dest_sel;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_enb_reg, busy,
        input  dest_sel
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_enb_reg, busy,
        output dest_sel
    );

endinterface

// File: rtl/router_fsm_dest_mux.sv
// Picks the per-FIFO empty / soft-reset flags for the header address
// and for the latched destination.
module router_fsm_dest_mux
    import router_pkg::*;
(
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [ADDR_W-1:0]   dest_sel,
    output logic                addr_empty,
    output logic                sel_empty,
    output logic                sel_soft_reset
);

    assign addr_empty     = pick_dest(fifo_empty, addr);
    assign sel_empty      = pick_dest(fifo_empty, dest_sel);
    assign sel_soft_reset = pick_dest(soft_reset, dest_sel);

endmodule

// File: rtl/router_fsm_controller.sv
// Moore controller sequencing header decode, payload/parity load and
// FIFO write enable for the 1x3 router.
module router_fsm_controller
    import router_pkg::*;
(
    input logic                   clockf,
    input logic                   resetnf,
    router_fsm_controller_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] dest_q;
    logic              addr_empty;
    logic              sel_empty;
    logic              sel_soft_reset;
    logic              hdr_ok;

    router_fsm_dest_mux u_mux (
        .fifo_empty     ({bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0}),
        .soft_reset     ({bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0}),
        .addr           (bus.data_in),
        .dest_sel       (dest_q),
        .addr_empty     (addr_empty),
        .sel_empty      (sel_empty),
        .sel_soft_reset (sel_soft_reset)
    );

    assign hdr_ok = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS:
                if (hdr_ok)
                    state_d = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
                state_d = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            LOAD_PARITY:
                state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
                state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the selected FIFO abandons the packet.
        if (state_q != DECODE_ADDRESS && sel_soft_reset)
            state_d = DECODE_ADDRESS;
    end

    always_ff @(posedge clockf or negedge resetnf) begin
        if (!resetnf) begin
            state_q <= DECODE_ADDRESS;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && hdr_ok)
                dest_q <= bus.data_in;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA)
                             | (state_q == LOAD_PARITY)
                             | (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q != DECODE_ADDRESS)
                             & (state_q != LOAD_DATA);
    assign bus.dest_sel      = dest_q;

endmodule
